// File: rtl/encoder_round_controller.sv
// Matrix encoder round controller: read, load, permute and write sequencing per word.
// Optional ENC_CTRL_MEM_WAIT_EN: READ and WRITE hold until mem_ack.
module encoder_round_controller #(
  parameter int WORDS  = 64,
  parameter int ADDR_W = 6,
  parameter int ROUNDS = 1,
  parameter int RND_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mem_ack,
  output logic              read_en,
  output logic              write_en,
  output logic [ADDR_W-1:0] addr,
  output logic              reg_en,
  output logic              mux_en,
  output logic              permute_en,
  output logic [RND_W-1:0]  round_idx,
  output logic              reg_rst,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEGIN,
    S_READ,
    S_PASS_IN,
    S_SWAP,
    S_PASS_OUT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic              rd_go, wr_go;
  logic              last_word, last_round;

`ifdef ENC_CTRL_MEM_WAIT_EN
  assign rd_go = mem_ack;
  assign wr_go = mem_ack;
`else
  logic unused_mem_ack;
  assign unused_mem_ack = mem_ack;
  assign rd_go = 1'b1;
  assign wr_go = 1'b1;
`endif

  assign last_word  = (addr_q == ADDR_W'(WORDS - 1));
  assign last_round = (round_q == RND_W'(ROUNDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    round_d = round_q;
    case (state_q)
      S_IDLE: begin
        addr_d  = '0;
        round_d = '0;
        if (start) state_d = S_BEGIN;
      end
      S_BEGIN:    state_d = S_READ;
      S_READ:     if (rd_go) state_d = S_PASS_IN;
      S_PASS_IN:  state_d = S_SWAP;
      S_SWAP: begin
        if (last_round) begin
          round_d = '0;
          state_d = S_PASS_OUT;
        end else begin
          round_d = round_q + RND_W'(1);
        end
      end
      S_PASS_OUT: state_d = S_WRITE;
      S_WRITE: begin
        if (wr_go) begin
          if (last_word) begin
            addr_d  = '0;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_BEGIN;
          end
        end
      end
      S_DONE:     state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        round_d = '0;
      end
    endcase
    // Cancel wins over every transition, including the final write.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      addr_d  = '0;
      round_d = '0;
    end
  end

  always_comb begin
    read_en    = 1'b0;
    write_en   = 1'b0;
    reg_en     = 1'b0;
    mux_en     = 1'b0;
    permute_en = 1'b0;
    reg_rst    = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE:     reg_rst = 1'b1;
      S_READ:     read_en = 1'b1;
      S_PASS_IN:  reg_en = 1'b1;
      S_SWAP:     permute_en = 1'b1;
      S_PASS_OUT: begin
        reg_en = 1'b1;
        mux_en = 1'b1;
      end
      S_WRITE:    write_en = 1'b1;
      S_DONE:     done = 1'b1;
      default:    reg_rst = 1'b0;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign addr      = addr_q;
  assign round_idx = round_q;

endmodule
